// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    // Transaction sequencing: idle, presenting a request to memory, waiting for its response.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    // Which requester the transaction in flight belongs to.
    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } arb_owner_e;

    // Contested data grants tolerated before fetch wins a tie.
    localparam int STARVE_MAX_DEF = 4;

    // Streak counter width; covers the legal STARVE_MAX range 1..15.
    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requests, with a starvation
// counter that lets fetch win a tie after a run of contested data grants.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic                dm_req,
    input  logic                arb_en,
    output logic                pick_fetch,
    output logic                pick_data,
    output logic [STREAK_W-1:0] streak
);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STARVE_MAX);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic                starved;

    // Data wins a tie unless fetch has lost STARVE_MAX contested rounds in a row.
    always_comb begin
        starved    = (streak_q == STREAK_LIMIT);
        pick_fetch = if_req && (!dm_req || starved);
        pick_data  = dm_req && !pick_fetch;
    end

    // Count data captures that happen while fetch is waiting; a fetch capture clears the run.
    always_comb begin
        streak_d = streak_q;
        if (arb_en && pick_fetch) begin
            streak_d = '0;
        end else if (arb_en && pick_data && if_req && (streak_q != STREAK_LIMIT)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Streak register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign streak = streak_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data
// stage. One transaction is in flight at a time; the response is routed
// back to whichever requester owns it.
//
// Handshakes: a requester raises *_req with its address/data and holds them
// until the matching *_gnt pulse, which is the capture point. Toward memory,
// mem_req stays high with mem_* stable until mem_ready; mem_req && mem_ready
// in one cycle is the issue. Memory answers each issue with exactly one
// mem_rvalid pulse, which is forwarded as a one-cycle *_rvalid to the owner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic                stall_dm,
    output logic                busy,
    output arb_state_e          dbg_state,
    output logic [STREAK_W-1:0] dbg_streak
);

    arb_state_e          state_q,     state_d;
    arb_owner_e          owner_q,     owner_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                rsp_fire;
    logic                arb_en;
    logic                pick_fetch;
    logic                pick_data;
    logic                capture;
    logic [STREAK_W-1:0] streak;

    // Arbitration happens when idle or in the cycle the outstanding response returns.
    // Responses outside WAIT belong to nothing (e.g. issued before a reset) and are dropped.
    // Gating with rst keeps grants low while reset is held.
    always_comb begin
        rsp_fire = (state_q == WAIT) && mem_rvalid;
        arb_en   = rst && ((state_q == IDLE) || rsp_fire);
        capture  = arb_en && (pick_fetch || pick_data);
    end

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .dm_req     (dm_req),
        .arb_en     (arb_en),
        .pick_fetch (pick_fetch),
        .pick_data  (pick_data),
        .streak     (streak)
    );

    // Next-state and next memory-port values; a capture overrides the state step.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ISSUE: begin
                if (mem_ready) begin
                    state_d   = WAIT;
                    mem_req_d = 1'b0;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            state_d   = ISSUE;
            mem_req_d = 1'b1;
            if (pick_fetch) begin
                owner_d     = FETCH;
                mem_we_d    = 1'b0;
                mem_addr_d  = if_addr;
                mem_wdata_d = '0;
            end else begin
                owner_d     = DATA;
                mem_we_d    = dm_we;
                mem_addr_d  = dm_addr;
                mem_wdata_d = dm_wdata;
            end
        end
    end

    // Transaction FSM with registered memory-port outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= FETCH;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Grants, response routing and stall indications toward the pipeline.
    always_comb begin
        if_gnt    = arb_en && pick_fetch;
        dm_gnt    = arb_en && pick_data;
        if_rvalid = rsp_fire && (owner_q == FETCH);
        dm_rvalid = rsp_fire && (owner_q == DATA);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        // A store acknowledgement carries no data.
        dm_rdata  = (dm_rvalid && !mem_we_q) ? mem_rdata : '0;
        stall_if  = if_req && !if_rvalid;
        stall_dm  = (dm_req || ((state_q != IDLE) && (owner_q == DATA))) && !dm_rvalid;
        busy      = (state_q != IDLE);
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign dbg_state  = state_q;
    assign dbg_streak = streak;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory responder model, a
// scoreboard monitor fed by expected queues, and per-cycle timing checks.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 1 + AW + DW;

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          mem_req, mem_we, mem_ready, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          stall_if, stall_dm, busy;
    arb_state_e    dbg_state;
    logic [STREAK_W-1:0] dbg_streak;

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .stall_if   (stall_if),
        .stall_dm   (stall_dm),
        .busy       (busy),
        .dbg_state  (dbg_state),
        .dbg_streak (dbg_streak)
    );

    // Scoreboard state
    logic [MW-1:0] exp_mem_q[$];
    logic [DW-1:0] exp_if_q[$];
    logic [DW-1:0] exp_dm_q[$];
    logic [DW-1:0] rsp_data_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Responder controls
    logic          auto_rsp      = 1'b1;
    int            rsp_delay     = 0;
    logic          inject_rvalid = 1'b0;
    logic [DW-1:0] inject_data   = '0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                     input logic [DW-1:0] rsp, input logic to_dm, input logic [DW-1:0] exp_rdata);
        exp_mem_q.push_back({we, addr, wdata});
        rsp_data_q.push_back(rsp);
        if (to_dm) exp_dm_q.push_back(exp_rdata);
        else       exp_if_q.push_back(exp_rdata);
    endfunction

    // Requesters must hold req until granted.
    a_if_hold: assert property (@(posedge clk) disable iff (!rst) (if_req && !if_gnt) |=> if_req)
        else $error("FAIL if_req_hold: if_req dropped before if_gnt");
    a_dm_hold: assert property (@(posedge clk) disable iff (!rst) (dm_req && !dm_gnt) |=> dm_req)
        else $error("FAIL dm_req_hold: dm_req dropped before dm_gnt");

    // Memory responder: one mem_rvalid rsp_delay cycles after the issue cycle.
    initial begin
        logic issue_seen;
        logic rsp_pending;
        int   rsp_wait;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        rsp_pending = 1'b0;
        rsp_wait    = 0;
        forever begin
            @(negedge clk);
            issue_seen = rst && mem_req && mem_ready && auto_rsp;
            if (!rst) rsp_pending = 1'b0;
            if (issue_seen) begin
                rsp_pending = 1'b1;
                rsp_wait    = rsp_delay;
            end
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (inject_rvalid) begin
                mem_rvalid = 1'b1;
                mem_rdata  = inject_data;
            end else if (rsp_pending) begin
                if (rsp_wait == 0) begin
                    mem_rvalid  = 1'b1;
                    mem_rdata   = (rsp_data_q.size() != 0) ? rsp_data_q.pop_front() : 32'hEEEE_EEEE;
                    rsp_pending = 1'b0;
                end else begin
                    rsp_wait--;
                end
            end
        end
    end

    // Monitor: compare every issue and every response against the expected queues.
    always @(negedge clk) begin
        logic [MW-1:0] e;
        if (rst) begin
            if (mem_req && mem_ready) begin
                check("issue_expected", (exp_mem_q.size() != 0), 1'b1);
                if (exp_mem_q.size() != 0) begin
                    e = exp_mem_q.pop_front();
                    check("issue_we", mem_we, e[MW-1]);
                    check("issue_addr", mem_addr, e[MW-2 -: AW]);
                    if (e[MW-1]) check("issue_wdata", mem_wdata, e[DW-1:0]);
                end
            end
            if (if_rvalid) begin
                check("if_rsp_expected", (exp_if_q.size() != 0), 1'b1);
                if (exp_if_q.size() != 0) check("if_rdata", if_rdata, exp_if_q.pop_front());
            end
            if (dm_rvalid) begin
                check("dm_rsp_expected", (exp_dm_q.size() != 0), 1'b1);
                if (exp_dm_q.size() != 0) check("dm_rdata", dm_rdata, exp_dm_q.pop_front());
            end
        end
    end

    // Driver helpers
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_if_q.size() != 0 || exp_dm_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, (n < 60), 1'b1);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h44;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h48; dm_wdata = 32'h1;
        mem_ready = 1'b1;

        // Reset state, with requests pending to show grants stay low.
        repeat (2) smp();
        check("rst_if_gnt", if_gnt, 1'b0);
        check("rst_dm_gnt", dm_gnt, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", dbg_state, IDLE);
        check("rst_streak", dbg_streak, 4'd0);
        cyc();
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        cyc();
        rst = 1'b1;

        // Fetch only, zero-wait memory.
        cyc();
        if_req = 1'b1; if_addr = 32'h0000_0010;
        push_txn(1'b0, 32'h10, 32'h0, 32'h0051_3093, 1'b0, 32'h0051_3093);
        smp();
        check("t1_if_gnt_c0", if_gnt, 1'b1);
        check("t1_dm_gnt_c0", dm_gnt, 1'b0);
        check("t1_mem_req_c0", mem_req, 1'b0);
        check("t1_stall_if_c0", stall_if, 1'b1);
        cyc();
        if_req = 1'b0;
        smp();
        check("t1_mem_req_c1", mem_req, 1'b1);
        check("t1_mem_addr_c1", mem_addr, 32'h10);
        check("t1_busy_c1", busy, 1'b1);
        cyc();
        smp();
        check("t1_if_rvalid_c2", if_rvalid, 1'b1);
        check("t1_if_rdata_c2", if_rdata, 32'h0051_3093);
        check("t1_mem_req_c2", mem_req, 1'b0);
        wait_idle("t1");

        // Contention: 4 data grants, then fetch, then data again.
        cyc();
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        for (int i = 0; i < 4; i++) push_txn(1'b0, 32'h300, 32'h0, 32'hD000_0000 + i, 1'b1, 32'hD000_0000 + i);
        push_txn(1'b0, 32'h200, 32'h0, 32'hF000_0200, 1'b0, 32'hF000_0200);
        push_txn(1'b0, 32'h300, 32'h0, 32'hD000_0004, 1'b1, 32'hD000_0004);
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) cyc();
            if (c == 9) if_req = 1'b0;
            smp();
            check($sformatf("t2_dm_gnt_c%0d", c), dm_gnt, (c % 2 == 0) && (c != 8));
            check($sformatf("t2_if_gnt_c%0d", c), if_gnt, (c == 8));
            if (c == 8) check("t2_streak_at_limit", dbg_streak, 4'd4);
            if (c == 9) check("t2_streak_cleared", dbg_streak, 4'd0);
        end
        cyc();
        dm_req = 1'b0;
        wait_idle("t2");

        // Store against a memory that stalls 3 cycles.
        cyc();
        mem_ready = 1'b0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        push_txn(1'b1, 32'h100, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'h0);
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) cyc();
            if (c == 1) dm_req = 1'b0;
            if (c == 4) mem_ready = 1'b1;
            smp();
            check($sformatf("t3_dm_gnt_c%0d", c), dm_gnt, (c == 0));
            check($sformatf("t3_mem_req_c%0d", c), mem_req, (c >= 1) && (c <= 4));
            check($sformatf("t3_stall_dm_c%0d", c), stall_dm, (c <= 4));
            check($sformatf("t3_dm_rvalid_c%0d", c), dm_rvalid, (c == 5));
            if (c >= 1 && c <= 4) begin
                check($sformatf("t3_mem_addr_c%0d", c), mem_addr, 32'h100);
                check($sformatf("t3_mem_wdata_c%0d", c), mem_wdata, 32'hDEAD_BEEF);
                check($sformatf("t3_mem_we_c%0d", c), mem_we, 1'b1);
            end
            if (c == 5) check("t3_dm_rdata_store_ack", dm_rdata, 32'h0);
        end
        wait_idle("t3");

        // Back-to-back: data grant in the same cycle as the fetch response.
        cyc();
        if_req = 1'b1; if_addr = 32'h20;
        push_txn(1'b0, 32'h20, 32'h0, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001);
        cyc();
        if_req = 1'b0;
        cyc();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1122_3344;
        push_txn(1'b1, 32'h40, 32'h1122_3344, 32'h0000_0077, 1'b1, 32'h0);
        smp();
        check("t4_if_rvalid", if_rvalid, 1'b1);
        check("t4_dm_gnt", dm_gnt, 1'b1);
        check("t4_if_gnt", if_gnt, 1'b0);
        cyc();
        dm_req = 1'b0;
        smp();
        check("t4_mem_req", mem_req, 1'b1);
        check("t4_mem_we", mem_we, 1'b1);
        check("t4_mem_addr", mem_addr, 32'h40);
        wait_idle("t4");

        // Reset while waiting; a stale response after release must be dropped.
        auto_rsp = 1'b0;
        cyc();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h5555_AAAA;
        exp_mem_q.push_back({1'b1, 32'h80, 32'h5555_AAAA});
        smp();
        cyc();
        dm_req = 1'b0;
        smp();
        cyc();
        smp();
        check("t5_state_wait", dbg_state, WAIT);
        check("t5_busy_wait", busy, 1'b1);
        cyc();
        rst = 1'b0;
        #1;
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_state", dbg_state, IDLE);
        check("t5_rst_mem_req", mem_req, 1'b0);
        check("t5_rst_mem_we", mem_we, 1'b0);
        check("t5_rst_mem_addr", mem_addr, 32'h0);
        check("t5_rst_mem_wdata", mem_wdata, 32'h0);
        check("t5_rst_stall_dm", stall_dm, 1'b0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        smp();
        inject_data   = 32'hBAD0_BAD0;
        inject_rvalid = 1'b1;
        cyc();
        smp();
        check("t5_stale_dm_rvalid", dm_rvalid, 1'b0);
        check("t5_stale_if_rvalid", if_rvalid, 1'b0);
        check("t5_stale_dm_rdata", dm_rdata, 32'h0);
        check("t5_stale_if_rdata", if_rdata, 32'h0);
        check("t5_stale_state", dbg_state, IDLE);
        check("t5_stale_mem_req", mem_req, 1'b0);
        inject_rvalid = 1'b0;
        auto_rsp = 1'b1;
        wait_idle("t5");

        // Fetch requests while a slow data load is in flight.
        rsp_delay = 3;
        cyc();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h60;
        push_txn(1'b0, 32'h60, 32'h0, 32'h0000_6006, 1'b1, 32'h0000_6006);
        push_txn(1'b0, 32'h64, 32'h0, 32'h0000_6401, 1'b0, 32'h0000_6401);
        push_txn(1'b0, 32'h64, 32'h0, 32'h0000_6402, 1'b0, 32'h0000_6402);
        smp();
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 1) dm_req = 1'b0;
            if (c == 2) begin
                if_req = 1'b1; if_addr = 32'h64;
            end
            smp();
            if (c >= 2) check($sformatf("t6_stall_if_c%0d", c), stall_if, (c < 10));
            check($sformatf("t6_if_rvalid_c%0d", c), if_rvalid, (c == 10));
            if (c >= 2 && c <= 4) check($sformatf("t6_stall_dm_c%0d", c), stall_dm, 1'b1);
            if (c == 5) begin
                check("t6_dm_rvalid_c5", dm_rvalid, 1'b1);
                check("t6_if_gnt_c5", if_gnt, 1'b1);
            end
        end
        cyc();
        if_req = 1'b0;
        wait_idle("t6");
        rsp_delay = 0;

        repeat (3) smp();
        check("final_mem_q_empty", exp_mem_q.size(), 0);
        check("final_if_q_empty", exp_if_q.size(), 0);
        check("final_dm_q_empty", exp_dm_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
